load_store_unit: RTL
====================

# load_store_unit

Load/store unit that sits between the MEM pipeline stage and the data memory and acts as the initiating end of the memory's address/write-enable/data interface. It accepts one byte, halfword or word load/store request at a time from the pipeline via a valid/ready handshake. It converts the byte address to a word index, performs read-modify-write for sub-word stores, and sign- or zero-extends sub-word loads. It returns exactly one response per accepted request.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sub-word stores use the low bits.
- resp_valid  out  1  one-cycle pulse, response valid.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved-size request; qualified by resp_valid.
- mem_add  out  32  word index to memory, {2'b00, addr[31:2]}.
- mem_wdata  out  32  write data to memory.
- mem_we  out  1  memory write enable; memory writes on clk rise while high.
- mem_rdata  in  32  memory read data, valid one cycle after mem_add is presented (synchronous read).

## Operation
- Byte lanes are little-endian within the word: byte offset k occupies bits [8k+7:8k]. Halfword offset 0 uses [15:0]; offset 2 uses [31:16].
- Request checks at accept:
  - Reserved size is an error.
  - Halfword with addr[0]=1 is an error.
  - Word with addr[1:0]≠0 is an error.
- FSM states: IDLE, RD_ADDR, RD_DATA, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch all request fields, drive mem_add, then:
  - error → RESP with err=1;
  - word store → WRITE;
  - load or sub-word store → RD_ADDR.
- RD_ADDR: mem_add is stable; go to RD_DATA.
- RD_DATA: capture mem_rdata.
  - Load: extract and extend into resp_rdata, then go to RESP.
  - Sub-word store: merge the store bytes into the captured word, drive mem_wdata, then go to WRITE.
- WRITE: mem_we=1 for exactly this one cycle; go to RESP.
- RESP: resp_valid=1 for one cycle; go to IDLE.
- An error request never touches memory: mem_we stays 0.
- Requests presented while req_ready=0 are ignored, not queued. The pipeline holds them.
- mem_add and mem_wdata hold their last value outside an access. Memory may only sample them while the FSM is not in IDLE.

## Timing
- Reset values:
  - state IDLE, req_ready 1;
  - resp_valid 0, resp_err 0, resp_rdata 0;
  - mem_add 0, mem_wdata 0, mem_we 0.
- Cycle 0 is the accepting edge. resp_valid is high in cycle:
  - 1 for an error;
  - 2 for a word store (mem_we in cycle 1);
  - 3 for a load;
  - 4 for a sub-word store (mem_we in cycle 3).
- Back-to-back throughput: the next request is accepted in the cycle after RESP, i.e. the unit is in IDLE again.
- resp_rdata and resp_err hold until the next RESP.
- Reset asserted in any state: immediately return to IDLE and drop mem_we and resp_valid, without waiting for clk. A sub-word store aborted before WRITE leaves memory unchanged. No response is ever produced for an aborted request.

## Test plan
- Preload word 2 = 0x8899AABB; lw addr 8 → resp_valid in cycle 3, resp_rdata 0x8899AABB, resp_err 0, mem_add 2, mem_we never high.
- Same preload: lb signed addr 9 → 0xFFFFFFAA; lbu addr 9 → 0x000000AA; lh signed addr 10 → 0xFFFF8899; lhu addr 8 → 0x0000AABB.
- Same preload: sb addr 11, wdata 0x12345677 → mem_we high exactly in cycle 3 with mem_add 2, mem_wdata 0x7799AABB; resp_valid in cycle 4; a following lw addr 8 returns 0x7799AABB.
- sw addr 40, wdata 500 → mem_we in cycle 1 with mem_add 10, mem_wdata 500, resp_valid in cycle 2; then lw addr 40 → 500. A second req_valid held during the busy cycles is accepted only after RESP.
- lw addr 6, lh addr 5 and size 11 → each returns resp_valid in cycle 1 with resp_err 1 and resp_rdata 0; mem_we stays 0 and memory is unchanged.
- sh addr 8 with rst_n pulsed low during RD_DATA → req_ready 1 immediately, no resp_valid, mem_we never asserted, word 2 unchanged; a fresh lw addr 8 then completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit bridging the MEM stage to a synchronous-read data memory.
// Word-indexed memory port; sub-word stores use read-modify-write, sub-word loads are extended.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_add,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  // state   | meaning
  // IDLE    | ready for a request
  // RD_ADDR | word address presented to memory
  // RD_DATA | memory data valid; extract (load) or merge (sub-word store)
  // WRITE   | mem_we asserted for one cycle
  // RESP    | response pulse
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        sign_q, sign_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_add_q, mem_add_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        req_err;
  logic [4:0]  lane_shift;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign req_err = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  assign lane_shift = {off_q, 3'b000};
  assign shifted    = mem_rdata >> lane_shift;
  assign lane_mask  = (size_q == 2'b00) ? (32'h0000_00FF << lane_shift)
                                        : (32'h0000_FFFF << lane_shift);
  assign merged     = (mem_rdata & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

  always_comb begin
    load_val = shifted;
    case (size_q)
      2'b00:   load_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    off_d        = off_q;
    sign_d       = sign_q;
    wdata_d      = wdata_q;
    mem_add_d    = mem_add_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          off_d   = req_addr[1:0];
          sign_d  = req_signed;
          wdata_d = req_wdata;
          if (req_err) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = RESP;
          end else begin
            mem_add_d = {2'b00, req_addr[31:2]};
            if (req_write && req_size == 2'b10) begin
              mem_wdata_d = req_wdata;
              state_d     = WRITE;
            end else begin
              state_d = RD_ADDR;
            end
          end
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        if (write_q) begin
          mem_wdata_d = merged;
          state_d     = WRITE;
        end else begin
          resp_rdata_d = load_val;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end
      end
      WRITE: begin
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      sign_q       <= 1'b0;
      wdata_q      <= 32'h0;
      mem_add_q    <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      off_q        <= off_d;
      sign_q       <= sign_d;
      wdata_q      <= wdata_d;
      mem_add_q    <= mem_add_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Handshake and strobes decode straight from state so reset drops them asynchronously.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_we     = (state_q == WRITE);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_add    = mem_add_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
